// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder
// Receive-side PWM decoder. Synchronizes the incoming PWM line, measures high
// time and period between rising edges, recovers the 4-bit speed code and
// flags a line that has stopped toggling (stuck high / stuck low).
module pwm_duty_decoder #(
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 192
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W+1:0] duty_cnt,
  output logic [CNT_W+1:0] period_cnt,
  output logic [3:0]       speed_code,
  output logic             sample_valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam int AW = CNT_W + 2;
  localparam int MW = CNT_W + 6;

  localparam logic [AW-1:0] TIMEOUT_CNT = AW'(TIMEOUT);
  localparam logic [AW-1:0] NOMINAL_CNT = AW'(2 ** CNT_W);
  localparam logic [AW-1:0] ONE_CNT     = AW'(1);
  localparam logic [MW-1:0] HALF_LSB    = MW'(2 ** (CNT_W - 1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    STUCK = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sdel_q, sdel_d;
  logic rise_q, rise_d;

  logic [AW-1:0] hi_acc_q, hi_acc_d;
  logic [AW-1:0] per_acc_q, per_acc_d;

  logic [AW-1:0] duty_q, duty_d;
  logic [AW-1:0] period_q, period_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          stuck_high_q, stuck_high_d;
  logic          stuck_low_q, stuck_low_d;

  // Counters saturate at all-ones so a long frame never wraps to a small value.
  function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
    return (v == '1) ? v : v + ONE_CNT;
  endfunction

  // Rounded duty*15/2^CNT_W against the nominal frame, clamped to 15.
  function automatic logic [3:0] calc_code(input logic [AW-1:0] h);
    logic [MW-1:0] ext;
    logic [MW-1:0] prod;
    logic [MW-1:0] quot;
    ext  = MW'(h);
    prod = (ext << 4) - ext;
    quot = (prod + HALF_LSB) >> CNT_W;
    return (quot > MW'(15)) ? 4'hF : quot[3:0];
  endfunction

  // Next-state logic: synchronizer chain, edge detect, measurement FSM.
  always_comb begin
    state_d      = state_q;
    hi_acc_d     = hi_acc_q;
    per_acc_d    = per_acc_q;
    duty_d       = duty_q;
    period_d     = period_q;
    code_d       = code_q;
    valid_d      = 1'b0;
    stuck_high_d = stuck_high_q;
    stuck_low_d  = stuck_low_q;

    sync1_d = pwm_in;
    sync2_d = sync1_q;
    sdel_d  = sync2_q;
    rise_d  = sync2_q & ~sdel_q;

    if (!enable) begin
      state_d      = IDLE;
      hi_acc_d     = '0;
      per_acc_d    = '0;
      stuck_high_d = 1'b0;
      stuck_low_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise_q) begin
            state_d   = ARMED;
            hi_acc_d  = ONE_CNT;
            per_acc_d = ONE_CNT;
          end
        end
        ARMED: begin
          if (rise_q) begin
            duty_d    = hi_acc_q;
            period_d  = per_acc_q;
            code_d    = calc_code(hi_acc_q);
            valid_d   = 1'b1;
            hi_acc_d  = ONE_CNT;
            per_acc_d = ONE_CNT;
          end else if (per_acc_q >= TIMEOUT_CNT) begin
            state_d = STUCK;
            valid_d = 1'b1;
            if (sdel_q) begin
              stuck_high_d = 1'b1;
              duty_d       = NOMINAL_CNT;
              period_d     = NOMINAL_CNT;
              code_d       = 4'hF;
            end else begin
              stuck_low_d = 1'b1;
              duty_d      = '0;
              period_d    = '0;
              code_d      = 4'h0;
            end
          end else begin
            per_acc_d = sat_inc(per_acc_q);
            if (sdel_q) begin
              hi_acc_d = sat_inc(hi_acc_q);
            end
          end
        end
        STUCK: begin
          if (rise_q) begin
            state_d      = ARMED;
            stuck_high_d = 1'b0;
            stuck_low_d  = 1'b0;
            hi_acc_d     = ONE_CNT;
            per_acc_d    = ONE_CNT;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sdel_q       <= 1'b0;
      rise_q       <= 1'b0;
      hi_acc_q     <= '0;
      per_acc_q    <= '0;
      duty_q       <= '0;
      period_q     <= '0;
      code_q       <= '0;
      valid_q      <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sdel_q       <= sdel_d;
      rise_q       <= rise_d;
      hi_acc_q     <= hi_acc_d;
      per_acc_q    <= per_acc_d;
      duty_q       <= duty_d;
      period_q     <= period_d;
      code_q       <= code_d;
      valid_q      <= valid_d;
      stuck_high_q <= stuck_high_d;
      stuck_low_q  <= stuck_low_d;
    end
  end

  assign duty_cnt     = duty_q;
  assign period_cnt   = period_q;
  assign speed_code   = code_q;
  assign sample_valid = valid_q;
  assign stuck_high   = stuck_high_q;
  assign stuck_low    = stuck_low_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder
// Table-driven bench for the PWM duty decoder plus hand-written sequences for
// stuck detection, reset/enable mid-frame and sample latency.
module tb_pwm_duty_decoder;

  localparam int CNT_W = 6;
  localparam int TIMEOUT = 192;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b1;
  logic             pwm_in = 1'b0;
  logic [CNT_W+1:0] duty_cnt;
  logic [CNT_W+1:0] period_cnt;
  logic [3:0]       speed_code;
  logic             sample_valid;
  logic             stuck_high;
  logic             stuck_low;

  pwm_duty_decoder #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .pwm_in       (pwm_in),
    .duty_cnt     (duty_cnt),
    .period_cnt   (period_cnt),
    .speed_code   (speed_code),
    .sample_valid (sample_valid),
    .stuck_high   (stuck_high),
    .stuck_low    (stuck_low)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    int high;
    int period;
    int frames;
    int exp_duty;
    int exp_period;
    int exp_code;
  } vec_t;

  vec_t vecs[20];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int pulses = 0;
  bit got_pulse = 0;
  int snap_duty, snap_period, snap_code, snap_sh, snap_sl;

  task automatic check_output(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample outputs on the falling edge, then drive pwm_in.
  task automatic step(input logic p);
    @(negedge clk);
    cyc++;
    got_pulse = sample_valid;
    if (sample_valid) begin
      pulses++;
      snap_duty   = int'(duty_cnt);
      snap_period = int'(period_cnt);
      snap_code   = int'(speed_code);
      snap_sh     = int'(stuck_high);
      snap_sl     = int'(stuck_low);
    end
    if (p && !pwm_in) last_rise_cyc = cyc;
    pwm_in = p;
  endtask

  task automatic do_reset();
    step(1'b0);
    rst = 1'b1;
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
    repeat (4) step(1'b0);
  endtask

  // Drives whole frames followed by one closing rise; every sample is checked.
  task automatic apply_stimulus(input int high, input int period, input int frames,
                                input int e_duty, input int e_per, input int e_code);
    pulses = 0;
    for (int f = 0; f < frames; f++) begin
      for (int c = 0; c < period; c++) begin
        step(c < high);
        if (got_pulse) check_sample(e_duty, e_per, e_code);
      end
    end
    step(1'b1);
    if (got_pulse) check_sample(e_duty, e_per, e_code);
    for (int t = 0; t < 8; t++) begin
      step(1'b0);
      if (got_pulse) check_sample(e_duty, e_per, e_code);
    end
    check_output("sample_count", pulses, frames);
  endtask

  task automatic check_sample(input int e_duty, input int e_per, input int e_code);
    check_output("duty_cnt", snap_duty, e_duty);
    check_output("period_cnt", snap_period, e_per);
    check_output("speed_code", snap_code, e_code);
    check_output("stuck_high_at_sample", snap_sh, 0);
    check_output("stuck_low_at_sample", snap_sl, 0);
    check_output("latency", cyc - last_rise_cyc, 4);
  endtask

  initial begin
    vecs[0]  = '{34, 64, 3, 34, 64, 8};
    vecs[1]  = '{4, 64, 1, 4, 64, 1};
    vecs[2]  = '{8, 64, 1, 8, 64, 2};
    vecs[3]  = '{12, 64, 1, 12, 64, 3};
    vecs[4]  = '{17, 64, 1, 17, 64, 4};
    vecs[5]  = '{21, 64, 1, 21, 64, 5};
    vecs[6]  = '{25, 64, 1, 25, 64, 6};
    vecs[7]  = '{29, 64, 1, 29, 64, 7};
    vecs[8]  = '{34, 64, 1, 34, 64, 8};
    vecs[9]  = '{38, 64, 1, 38, 64, 9};
    vecs[10] = '{42, 64, 1, 42, 64, 10};
    vecs[11] = '{46, 64, 1, 46, 64, 11};
    vecs[12] = '{50, 64, 1, 50, 64, 12};
    vecs[13] = '{55, 64, 1, 55, 64, 13};
    vecs[14] = '{59, 64, 1, 59, 64, 14};
    vecs[15] = '{63, 64, 1, 63, 64, 15};
    vecs[16] = '{50, 100, 2, 50, 100, 12};
    vecs[17] = '{70, 100, 1, 70, 100, 15};
    vecs[18] = '{1, 64, 2, 1, 64, 0};
    vecs[19] = '{10, 192, 1, 10, 192, 2};

    // Reset state.
    rst = 1'b1;
    repeat (3) step(1'b0);
    check_output("rst_duty", int'(duty_cnt), 0);
    check_output("rst_period", int'(period_cnt), 0);
    check_output("rst_code", int'(speed_code), 0);
    check_output("rst_valid", int'(sample_valid), 0);
    check_output("rst_stuck_high", int'(stuck_high), 0);
    check_output("rst_stuck_low", int'(stuck_low), 0);
    rst = 1'b0;

    // Table vectors, each from a fresh reset.
    for (int i = 0; i < 20; i++) begin
      do_reset();
      apply_stimulus(vecs[i].high, vecs[i].period, vecs[i].frames,
                     vecs[i].exp_duty, vecs[i].exp_period, vecs[i].exp_code);
      check_output("no_stuck_high_after", int'(stuck_high), 0);
      check_output("no_stuck_low_after", int'(stuck_low), 0);
    end

    // Line held low after one rise -> stuck_low with a single sample pulse.
    do_reset();
    pulses = 0;
    step(1'b1);
    repeat (250) step(1'b0);
    check_output("stuck_low_pulses", pulses, 1);
    check_output("stuck_low_flag_at_pulse", snap_sl, 1);
    check_output("stuck_low_duty", snap_duty, 0);
    check_output("stuck_low_period", snap_period, 0);
    check_output("stuck_low_code", snap_code, 0);
    check_output("stuck_low_held", int'(stuck_low), 1);
    check_output("stuck_low_valid_idle", int'(sample_valid), 0);

    // Line held high -> stuck_high, then recovery needs two rises.
    do_reset();
    pulses = 0;
    repeat (250) step(1'b1);
    check_output("stuck_high_pulses", pulses, 1);
    check_output("stuck_high_flag_at_pulse", snap_sh, 1);
    check_output("stuck_high_duty", snap_duty, 64);
    check_output("stuck_high_period", snap_period, 64);
    check_output("stuck_high_code", snap_code, 15);
    repeat (10) step(1'b0);
    check_output("stuck_high_held", int'(stuck_high), 1);
    apply_stimulus(34, 64, 1, 34, 64, 8);
    check_output("stuck_high_cleared", int'(stuck_high), 0);

    // Synchronous reset mid-frame clears outputs; two more rises needed.
    do_reset();
    apply_stimulus(34, 64, 1, 34, 64, 8);
    repeat (10) step(1'b0);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    step(1'b0);
    check_output("midrst_duty", int'(duty_cnt), 0);
    check_output("midrst_period", int'(period_cnt), 0);
    check_output("midrst_code", int'(speed_code), 0);
    check_output("midrst_valid", int'(sample_valid), 0);
    apply_stimulus(20, 64, 1, 20, 64, 5);

    // enable low mid-frame holds outputs; two more rises needed.
    do_reset();
    apply_stimulus(34, 64, 1, 34, 64, 8);
    repeat (3) step(1'b0);
    enable = 1'b0;
    repeat (4) step(1'b0);
    check_output("dis_duty_held", int'(duty_cnt), 34);
    check_output("dis_period_held", int'(period_cnt), 64);
    check_output("dis_code_held", int'(speed_code), 8);
    check_output("dis_valid", int'(sample_valid), 0);
    check_output("dis_stuck_low", int'(stuck_low), 0);
    enable = 1'b1;
    step(1'b0);
    apply_stimulus(20, 64, 1, 20, 64, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
